// File: rtl/l2_arbiter_rr_pkg.sv
// Shared types for the L1-to-L2 line arbiter: LC-3b word/line types plus
// the arbiter's state and mode encodings.
package l2_arbiter_rr_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] cache_line;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_t;

endpackage

// File: rtl/l2_arbiter_rr_if.sv
// Bundle of the N requester channels and the single L2 port seen by the arbiter.
// The slave view is the arbiter itself; the master view is its environment.
interface l2_arbiter_rr_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
);
  localparam int ID_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]        ch_read;
  logic [NUM_CH-1:0]        ch_write;
  logic [NUM_CH*ADDR_W-1:0] ch_address;
  logic [NUM_CH*LINE_W-1:0] ch_wdata;
  logic [NUM_CH-1:0]        ch_resp;
  logic [LINE_W-1:0]        ch_rdata;

  logic                     l2_read;
  logic                     l2_write;
  logic [ADDR_W-1:0]        l2_address;
  logic [LINE_W-1:0]        l2_wdata;
  logic                     l2_resp;
  logic [LINE_W-1:0]        l2_rdata;

  logic [ID_W-1:0]          grant_id;

  modport slave (
    input  ch_read, ch_write, ch_address, ch_wdata, l2_resp, l2_rdata,
    output ch_resp, ch_rdata, l2_read, l2_write, l2_address, l2_wdata, grant_id
  );

  modport master (
    output ch_read, ch_write, ch_address, ch_wdata, l2_resp, l2_rdata,
    input  ch_resp, ch_rdata, l2_read, l2_write, l2_address, l2_wdata, grant_id
  );

endinterface

// File: rtl/l2_arbiter_rr_rr_pick.sv
// rr_pick: rotate the request vector to start at 'start', then priority-encode
// the lowest set bit; returns the absolute winner index and an any-valid flag.
module l2_arbiter_rr_rr_pick #(
  parameter  int NUM_CH = 2,
  localparam int ID_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [ID_W-1:0]   start,
  output logic [ID_W-1:0]   idx,
  output logic              valid
);

  logic [2*NUM_CH-1:0] dbl;
  logic [NUM_CH-1:0]   rot;
  int                  off;
  int                  sum;

  // Doubling the vector makes the wrap a plain shift: rot[k] = req[(start+k) % NUM_CH].
  assign dbl   = {req, req} >> start;
  assign rot   = dbl[NUM_CH-1:0];
  assign valid = |req;

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, otherwise a path that skips it infers a latch.
  always_comb begin
    off = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (rot[k]) off = k;
    end
    sum = int'(start) + off;
    if (sum >= NUM_CH) sum = sum - NUM_CH;
    idx = ID_W'(sum);
  end

endmodule

// File: rtl/l2_arbiter_rr.sv
// N-channel arbiter onto a single L2 port, one transaction in flight; request
// registered toward L2, response steered back to the granted channel only.
module l2_arbiter_rr
  import l2_arbiter_rr_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128,
  parameter int MODE   = 0
) (
  input  logic             clk,
  input  logic             rst,
  l2_arbiter_rr_if.slave   bus
);

  localparam int        ID_W   = $clog2(NUM_CH);
  localparam arb_mode_t MODE_E = arb_mode_t'(MODE);

  arb_state_t        state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   start;
  logic [ID_W-1:0]   win;
  logic              any;
  logic [NUM_CH-1:0] req;

  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [LINE_W-1:0] sel_wdata;

  // A write takes precedence when a channel raises both read and write.
  assign req   = bus.ch_read | bus.ch_write;
  assign start = (MODE_E == ARB_FIXED) ? '0 : ptr;

  l2_arbiter_rr_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
    .req   (req),
    .start (start),
    .idx   (win),
    .valid (any)
  );

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (win == ID_W'(i)) begin
        sel_write = bus.ch_write[i];
        sel_addr  = bus.ch_address[i*ADDR_W +: ADDR_W];
        sel_wdata = bus.ch_wdata[i*LINE_W +: LINE_W];
      end
    end
  end

  always_comb begin
    bus.ch_resp = '0;
    if (state == BUSY && bus.l2_resp) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.grant_id == ID_W'(i)) bus.ch_resp[i] = 1'b1;
      end
    end
  end

  assign bus.ch_rdata = bus.l2_rdata;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the address/data registers are reset too, since their idle value
      // is visible on the L2 port rather than being don't-care storage.
      state          <= IDLE;
      ptr            <= '0;
      bus.grant_id   <= '0;
      bus.l2_read    <= 1'b0;
      bus.l2_write   <= 1'b0;
      bus.l2_address <= '0;
      bus.l2_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            bus.l2_write   <= sel_write;
            bus.l2_read    <= ~sel_write;
            bus.l2_address <= sel_addr;
            bus.l2_wdata   <= sel_wdata;
            bus.grant_id   <= win;
            state          <= BUSY;
          end
        end
        BUSY: begin
          if (bus.l2_resp) begin
            bus.l2_read  <= 1'b0;
            bus.l2_write <= 1'b0;
            ptr          <= (bus.grant_id == ID_W'(NUM_CH - 1)) ? '0 : bus.grant_id + 1'b1;
            state        <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_arbiter_rr.sv
// Directed bench for l2_arbiter_rr: 2-channel round-robin, 4-channel fixed
// priority and 3-channel round-robin instances sharing one clock and reset.
module tb_l2_arbiter_rr;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [127:0] LINE_A5 = {16{8'hA5}};
  localparam logic [127:0] LINE_0F = {16{8'h0F}};

  always #5 clk = ~clk;

  l2_arbiter_rr_if #(.NUM_CH(2), .ADDR_W(16), .LINE_W(128)) bus_a ();
  l2_arbiter_rr_if #(.NUM_CH(4), .ADDR_W(16), .LINE_W(128)) bus_b ();
  l2_arbiter_rr_if #(.NUM_CH(3), .ADDR_W(16), .LINE_W(128)) bus_c ();

  l2_arbiter_rr #(.NUM_CH(2), .ADDR_W(16), .LINE_W(128), .MODE(0)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a));
  l2_arbiter_rr #(.NUM_CH(4), .ADDR_W(16), .LINE_W(128), .MODE(1)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b));
  l2_arbiter_rr #(.NUM_CH(3), .ADDR_W(16), .LINE_W(128), .MODE(0)) dut_c (
    .clk(clk), .rst(rst), .bus(bus_c));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are checked after settling.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  int exp_a[4] = '{0, 1, 0, 1};
  int exp_c[6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    rst = 1'b1;
    bus_a.ch_read = '0; bus_a.ch_write = '0; bus_a.ch_address = '0; bus_a.ch_wdata = '0;
    bus_a.l2_resp = 1'b0; bus_a.l2_rdata = '0;
    bus_b.ch_read = '0; bus_b.ch_write = '0; bus_b.ch_address = '0; bus_b.ch_wdata = '0;
    bus_b.l2_resp = 1'b0; bus_b.l2_rdata = '0;
    bus_c.ch_read = '0; bus_c.ch_write = '0; bus_c.ch_address = '0; bus_c.ch_wdata = '0;
    bus_c.l2_resp = 1'b0; bus_c.l2_rdata = '0;
    repeat (2) nxt();

    // Reset state
    check("rst l2_read",    bus_a.l2_read,    0);
    check("rst l2_write",   bus_a.l2_write,   0);
    check("rst l2_address", bus_a.l2_address, 0);
    check("rst l2_wdata",   bus_a.l2_wdata,   0);
    check("rst ch_resp",    bus_a.ch_resp,    0);
    check("rst grant_id",   bus_a.grant_id,   0);
    check("rst b l2_read",  bus_b.l2_read,    0);
    check("rst c l2_read",  bus_c.l2_read,    0);
    rst = 1'b0;

    // Single read from channel 1
    bus_a.ch_read = 2'b10;
    bus_a.ch_address = {16'h1230, 16'h0000};
    #1;
    check("rd idle ch_resp", bus_a.ch_resp, 0);
    check("rd idle l2_read", bus_a.l2_read, 0);
    nxt();
    check("rd l2_read",    bus_a.l2_read,    1);
    check("rd l2_write",   bus_a.l2_write,   0);
    check("rd l2_address", bus_a.l2_address, 16'h1230);
    check("rd grant_id",   bus_a.grant_id,   1);
    nxt();
    nxt();
    check("rd held l2_read", bus_a.l2_read, 1);
    bus_a.l2_resp = 1'b1;
    bus_a.l2_rdata = LINE_A5;
    #1;
    check("rd ch_resp",  bus_a.ch_resp,  2'b10);
    check("rd ch_rdata", bus_a.ch_rdata, LINE_A5);
    nxt();
    bus_a.l2_resp = 1'b0;
    bus_a.l2_rdata = '0;
    bus_a.ch_read = '0;
    #1;
    check("rd done l2_read", bus_a.l2_read, 0);
    check("rd done ch_resp", bus_a.ch_resp, 0);

    // Both channels held: round-robin alternation starting from ptr = 0
    bus_a.ch_read = 2'b11;
    bus_a.ch_address = {16'h2000, 16'h1000};
    for (int g = 0; g < 4; g++) begin
      nxt();
      check("rr2 grant_id",   bus_a.grant_id,   exp_a[g]);
      check("rr2 l2_address", bus_a.l2_address, 16'h1000 * (exp_a[g] + 1));
      bus_a.l2_resp = 1'b1;
      #1;
      check("rr2 ch_resp", bus_a.ch_resp, 128'(1) << exp_a[g]);
      nxt();
      bus_a.l2_resp = 1'b0;
      #1;
      check("rr2 idle l2_read", bus_a.l2_read, 0);
    end
    bus_a.ch_read = '0;

    // Read and write together on channel 0: write wins
    bus_a.ch_read = 2'b01;
    bus_a.ch_write = 2'b01;
    bus_a.ch_wdata = {128'h0, LINE_0F};
    nxt();
    check("rw l2_write", bus_a.l2_write, 1);
    check("rw l2_read",  bus_a.l2_read,  0);
    check("rw l2_wdata", bus_a.l2_wdata, LINE_0F);
    check("rw grant_id", bus_a.grant_id, 0);
    bus_a.l2_resp = 1'b1;
    #1;
    check("rw ch_resp", bus_a.ch_resp, 2'b01);
    nxt();
    bus_a.l2_resp = 1'b0;
    bus_a.ch_read = '0;
    bus_a.ch_write = '0;
    #1;
    check("rw done l2_write", bus_a.l2_write, 0);

    // Writeback then allocate on channel 0 while channel 1 waits (ptr = 1 now,
    // so channel 0 only wins because it is alone at the first grant)
    bus_a.ch_write = 2'b01;
    bus_a.ch_address = {16'h0000, 16'h3000};
    bus_a.ch_wdata = {LINE_0F, LINE_A5};
    nxt();
    check("wb grant_id",   bus_a.grant_id,   0);
    check("wb l2_write",   bus_a.l2_write,   1);
    check("wb l2_address", bus_a.l2_address, 16'h3000);
    bus_a.ch_read = 2'b10;
    bus_a.ch_address = {16'h4000, 16'h3000};
    nxt();
    check("wb busy l2_address", bus_a.l2_address, 16'h3000);
    check("wb busy grant_id",   bus_a.grant_id,   0);
    bus_a.l2_resp = 1'b1;
    #1;
    check("wb ch_resp", bus_a.ch_resp, 2'b01);
    nxt();
    bus_a.l2_resp = 1'b0;
    bus_a.ch_write = '0;
    bus_a.ch_read = 2'b11;
    bus_a.ch_address = {16'h4000, 16'h3040};
    #1;
    check("wb idle ch_resp", bus_a.ch_resp, 0);
    nxt();
    check("alloc1 grant_id",   bus_a.grant_id,   1);
    check("alloc1 l2_read",    bus_a.l2_read,    1);
    check("alloc1 l2_address", bus_a.l2_address, 16'h4000);
    bus_a.l2_resp = 1'b1;
    #1;
    check("alloc1 ch_resp", bus_a.ch_resp, 2'b10);
    nxt();
    bus_a.l2_resp = 1'b0;
    bus_a.ch_read = 2'b01;
    nxt();
    check("alloc0 grant_id",   bus_a.grant_id,   0);
    check("alloc0 l2_read",    bus_a.l2_read,    1);
    check("alloc0 l2_write",   bus_a.l2_write,   0);
    check("alloc0 l2_address", bus_a.l2_address, 16'h3040);
    bus_a.l2_resp = 1'b1;
    #1;
    check("alloc0 ch_resp", bus_a.ch_resp, 2'b01);
    nxt();
    bus_a.l2_resp = 1'b0;
    bus_a.ch_read = '0;

    // Reset while BUSY with channel 1 (ptr = 1 here)
    bus_a.ch_read = 2'b10;
    bus_a.ch_address = {16'h5000, 16'h0000};
    bus_a.ch_wdata = {LINE_0F, 128'h0};
    nxt();
    check("rb grant_id", bus_a.grant_id, 1);
    check("rb l2_read",  bus_a.l2_read,  1);
    rst = 1'b1;
    bus_a.ch_read = '0;
    #1;
    check("rb rst ch_resp", bus_a.ch_resp, 0);
    nxt();
    rst = 1'b0;
    bus_a.l2_resp = 1'b1;
    #1;
    check("rb l2_read after",    bus_a.l2_read,    0);
    check("rb l2_write after",   bus_a.l2_write,   0);
    check("rb l2_address after", bus_a.l2_address, 0);
    check("rb l2_wdata after",   bus_a.l2_wdata,   0);
    check("rb grant_id after",   bus_a.grant_id,   0);
    check("rb late resp ch_resp", bus_a.ch_resp,   0);
    nxt();
    bus_a.l2_resp = 1'b0;
    #1;
    check("rb late resp l2_read", bus_a.l2_read, 0);
    bus_a.ch_read = 2'b11;
    bus_a.ch_address = {16'h6000, 16'h6100};
    nxt();
    check("rb ptr0 grant_id",   bus_a.grant_id,   0);
    check("rb ptr0 l2_address", bus_a.l2_address, 16'h6100);
    bus_a.ch_read = 2'b01;
    bus_a.l2_resp = 1'b1;
    nxt();
    bus_a.l2_resp = 1'b0;
    bus_a.ch_read = '0;

    // Fixed priority, 4 channels, 1 and 3 requesting: 1 always wins
    bus_b.ch_read = 4'b1010;
    bus_b.ch_address = {16'h3333, 16'h0000, 16'h1111, 16'h0000};
    for (int g = 0; g < 3; g++) begin
      nxt();
      check("fp grant_id",   bus_b.grant_id,   1);
      check("fp l2_address", bus_b.l2_address, 16'h1111);
      bus_b.l2_resp = 1'b1;
      #1;
      check("fp ch_resp", bus_b.ch_resp, 4'b0010);
      nxt();
      bus_b.l2_resp = 1'b0;
    end
    bus_b.ch_read = 4'b1000;
    nxt();
    check("fp ch3 grant_id",   bus_b.grant_id,   3);
    check("fp ch3 l2_address", bus_b.l2_address, 16'h3333);
    bus_b.l2_resp = 1'b1;
    #1;
    check("fp ch3 ch_resp", bus_b.ch_resp, 4'b1000);
    nxt();
    bus_b.l2_resp = 1'b0;
    bus_b.ch_read = '0;

    // Round-robin over 3 channels: wrap from 2 back to 0
    bus_c.ch_read = 3'b111;
    bus_c.ch_address = {16'h002C, 16'h001C, 16'h000C};
    for (int g = 0; g < 6; g++) begin
      nxt();
      check("rr3 grant_id",   bus_c.grant_id,   exp_c[g]);
      check("rr3 l2_address", bus_c.l2_address, 16'h000C + 16'h0010 * exp_c[g]);
      bus_c.l2_resp = 1'b1;
      #1;
      check("rr3 ch_resp", bus_c.ch_resp, 128'(1) << exp_c[g]);
      nxt();
      bus_c.l2_resp = 1'b0;
    end
    bus_c.ch_read = '0;
    nxt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
